up_down_counter255_tester: RTL and testbench

Programmable 8-bit up/down bounce counter with a microprocessor-style register interface. A host writes four registers over a shared bidirectional data bus: preload, upper limit, lower limit and cycle count. A one-clock `start` pulse then runs the counter between the limits for the programmed number of cycles. The block sits as a memory-mapped peripheral; `count`, `dir`, `ec` and `err` are status outputs for the host and downstream logic.

---
 rtl/up_down_counter255_tester.sv | 145 ++++++++++++++
 tb/tb_up_down_counter255_tester.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/up_down_counter255_tester.sv
// Programmable 8-bit up/down bounce counter with a host register interface.
// Host writes PLR/ULR/LLR/CCR over din; start runs the counter between limits.
module up_down_counter255_tester (
    inout  wire  [7:0] din,
    input  logic       clk,
    input  logic       ncs,
    input  logic       nrd,
    input  logic       nwr,
    input  logic       start,
    input  logic       reset,
    input  logic       a0,
    input  logic       a1,
    output logic [7:0] count,
    output logic       err,
    output logic       ec,
    output logic       dir
);

    typedef enum logic [1:0] {
        IDLE,
        UP,
        DOWN,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] plr;
    logic [7:0] ulr;
    logic [7:0] llr;
    logic [7:0] ccr;
    logic [7:0] w_ulr;
    logic [7:0] w_llr;
    logic [7:0] w_ccr;
    logic [7:0] cyc;
    logic [7:0] rd_data;
    logic [7:0] llr_p1;
    logic [7:0] cyc_nx;
    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic       go;
    logic       cfg_ok;

    assign addr   = {a1, a0};
    assign wr_en  = !ncs && !nwr;
    assign rd_en  = !ncs && !nrd && nwr;
    assign din    = rd_en ? rd_data : 8'hzz;
    assign llr_p1 = w_llr + 8'd1;
    assign cyc_nx = cyc + 8'd1;
    assign go     = start && (state == IDLE || state == DONE);
    assign cfg_ok = (llr < ulr) && (llr <= plr) && (plr <= ulr)
                 && (ccr != 8'd0);

    // Host-visible register file, writable in every state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            plr <= 8'd0;
            ulr <= 8'd0;
            llr <= 8'd0;
            ccr <= 8'd0;
        end else if (wr_en) begin
            unique case (addr)
                2'b00: plr <= din;
                2'b01: ulr <= din;
                2'b10: llr <= din;
                2'b11: ccr <= din;
            endcase
        end
    end

    // Read-back mux for the addressed register
    always_comb begin
        rd_data = 8'd0;
        unique case (addr)
            2'b00: rd_data = plr;
            2'b01: rd_data = ulr;
            2'b10: rd_data = llr;
            2'b11: rd_data = ccr;
        endcase
    end

    // Run FSM: validate and snapshot on start, then bounce between limits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= 8'd0;
            dir   <= 1'b0;
            ec    <= 1'b0;
            err   <= 1'b0;
            cyc   <= 8'd0;
            w_ulr <= 8'd0;
            w_llr <= 8'd0;
            w_ccr <= 8'd0;
        end else if (go) begin
            if (!cfg_ok) begin
                err   <= 1'b1;
                ec    <= 1'b0;
                state <= IDLE;
            end else begin
                w_ulr <= ulr;
                w_llr <= llr;
                w_ccr <= ccr;
                count <= plr;
                dir   <= 1'b1;
                cyc   <= 8'd0;
                err   <= 1'b0;
                ec    <= 1'b0;
                state <= UP;
            end
        end else begin
            case (state)
                UP: begin
                    if (count < w_ulr) begin
                        count <= count + 8'd1;
                    end else begin
                        dir   <= 1'b0;
                        count <= w_ulr - 8'd1;
                        state <= DOWN;
                    end
                end
                DOWN: begin
                    if (count > llr_p1) begin
                        count <= count - 8'd1;
                    end else if (count == llr_p1) begin
                        count <= w_llr;
                        cyc   <= cyc_nx;
                        if (cyc_nx == w_ccr) begin
                            ec    <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        dir   <= 1'b1;
                        count <= llr_p1;
                        state <= UP;
                    end
                end
                IDLE, DONE: begin
                    state <= state;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_up_down_counter255_tester.sv
// Bench for up_down_counter255_tester: bus vectors, directed runs,
// error cases and randomized runs against a closed-form trajectory model.
module tb_up_down_counter255_tester;

    wire  [7:0] din;
    logic [7:0] dout;
    logic       drv;
    logic       clk;
    logic       ncs;
    logic       nrd;
    logic       nwr;
    logic       start;
    logic       reset;
    logic       a0;
    logic       a1;
    logic [7:0] count;
    logic       err;
    logic       ec;
    logic       dir;

    int total;
    int bad;

    assign din = drv ? dout : 8'hzz;

    up_down_counter255_tester dut (
        .din   (din),
        .clk   (clk),
        .ncs   (ncs),
        .nrd   (nrd),
        .nwr   (nwr),
        .start (start),
        .reset (reset),
        .a0    (a0),
        .a1    (a1),
        .count (count),
        .err   (err),
        .ec    (ec),
        .dir   (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] a;
        logic       cs_n;
        logic [7:0] wd;
        logic [7:0] exp;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        {a1, a0} = a;
        dout = d;
        drv  = 1'b1;
        ncs  = 1'b0;
        nwr  = 1'b0;
        tick();
        ncs  = 1'b1;
        nwr  = 1'b1;
        drv  = 1'b0;
    endtask

    task automatic bus_read_chk(input string nm, input logic [1:0] a,
                                input logic [7:0] exp);
        {a1, a0} = a;
        drv = 1'b0;
        nwr = 1'b1;
        ncs = 1'b0;
        nrd = 1'b0;
        #1;
        chk(nm, int'(din), int'(exp));
        ncs = 1'b1;
        nrd = 1'b1;
    endtask

    // Expected outputs k edges after the load edge, from the bounce rules
    function automatic void model(input int p, input int u, input int l,
                                  input int c, input int k,
                                  output int cnt, output int d,
                                  output int e);
        int up;
        int span;
        int lat;
        int ph;
        up   = u - p;
        span = u - l;
        lat  = up + span + (c - 1) * 2 * span;
        e    = 0;
        if (k >= lat) begin
            cnt = l;
            d   = 0;
            e   = 1;
        end else if (k <= up) begin
            cnt = p + k;
            d   = 1;
        end else begin
            ph = (k - up) % (2 * span);
            if (ph == 0) begin
                cnt = u;
                d   = 1;
            end else if (ph <= span) begin
                cnt = u - ph;
                d   = 0;
            end else begin
                cnt = l + ph - span;
                d   = 1;
            end
        end
    endfunction

    // mode 0: quiet, 1: random host traffic, 2: ULR=200 + start at k=3
    task automatic run_check(input string nm, input int p, input int u,
                             input int l, input int c, input int mode);
        int lat;
        int ec_cnt;
        int ec_d;
        int ec_e;
        lat = (u - p) + (u - l) + (c - 1) * 2 * (u - l);
        bus_write(2'b00, 8'(p));
        bus_write(2'b01, 8'(u));
        bus_write(2'b10, 8'(l));
        bus_write(2'b11, 8'(c));
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= lat + 2; k++) begin
            model(p, u, l, c, k, ec_cnt, ec_d, ec_e);
            chk({nm, "_count"}, int'(count), ec_cnt);
            chk({nm, "_dir"}, int'(dir), ec_d);
            chk({nm, "_ec"}, int'(ec), ec_e);
            chk({nm, "_err"}, int'(err), 0);
            if (k < lat + 2) begin
                if (k < lat && ((mode == 1 && $urandom_range(0, 3) == 0)
                                || (mode == 2 && k == 3))) begin
                    if (mode == 2) begin
                        {a1, a0} = 2'b01;
                        dout = 8'd200;
                        start = 1'b1;
                    end else begin
                        {a1, a0} = 2'($urandom_range(0, 3));
                        dout = 8'($urandom_range(0, 255));
                        start = 1'($urandom_range(0, 1));
                    end
                    drv = 1'b1;
                    ncs = 1'b0;
                    nwr = 1'b0;
                    tick();
                    drv = 1'b0;
                    ncs = 1'b1;
                    nwr = 1'b1;
                    start = 1'b0;
                end else begin
                    tick();
                end
            end
        end
    endtask

    task automatic chk_outs(input string nm, input int c, input int d,
                            input int e, input int r);
        chk({nm, "_count"}, int'(count), c);
        chk({nm, "_dir"}, int'(dir), d);
        chk({nm, "_ec"}, int'(ec), e);
        chk({nm, "_err"}, int'(err), r);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int p;
        int u;
        int l;
        int c;
        int span;
        total = 0;
        bad   = 0;
        vecs[0] = '{2'b00, 1'b0, 8'h11, 8'h11};
        vecs[1] = '{2'b01, 1'b0, 8'h22, 8'h22};
        vecs[2] = '{2'b10, 1'b0, 8'h33, 8'h33};
        vecs[3] = '{2'b11, 1'b0, 8'h44, 8'h44};
        vecs[4] = '{2'b00, 1'b1, 8'h99, 8'h11};
        vecs[5] = '{2'b11, 1'b1, 8'h00, 8'h44};
        vecs[6] = '{2'b01, 1'b0, 8'hff, 8'hff};
        vecs[7] = '{2'b10, 1'b0, 8'h00, 8'h00};

        // reset held while the host tries to write
        reset = 1'b0;
        start = 1'b0;
        nrd   = 1'b1;
        ncs   = 1'b0;
        nwr   = 1'b0;
        drv   = 1'b1;
        dout  = 8'h77;
        {a1, a0} = 2'b11;
        repeat (3) tick();
        chk_outs("reset", 0, 0, 0, 0);
        ncs   = 1'b1;
        nwr   = 1'b1;
        drv   = 1'b0;
        reset = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus_read_chk("reset_reg", 2'(i), 8'h00);
        end

        // table-driven register write/read-back
        foreach (vecs[i]) begin
            {a1, a0} = vecs[i].a;
            dout = vecs[i].wd;
            drv  = 1'b1;
            ncs  = vecs[i].cs_n;
            nwr  = 1'b0;
            tick();
            ncs  = 1'b1;
            nwr  = 1'b1;
            drv  = 1'b0;
            bus_read_chk("vec_read", vecs[i].a, vecs[i].exp);
        end

        // both strobes low: host write owns the bus
        {a1, a0} = 2'b00;
        dout = 8'hee;
        drv  = 1'b1;
        ncs  = 1'b0;
        nrd  = 1'b0;
        nwr  = 1'b0;
        #1;
        chk("wr_wins_bus", int'(din), 8'hee);
        tick();
        ncs = 1'b1;
        nrd = 1'b1;
        nwr = 1'b1;
        drv = 1'b0;
        bus_read_chk("wr_wins_reg", 2'b00, 8'hee);
        dout = 8'h00;
        drv  = 1'b1;
        nrd  = 1'b0;
        #1;
        chk("no_cs_bus", int'(din), 0);
        nrd = 1'b1;
        ncs = 1'b0;
        #1;
        chk("no_rd_bus", int'(din), 0);
        ncs = 1'b1;
        drv = 1'b0;

        // basic run with host ULR write and start pulse mid-run
        run_check("basic", 10, 15, 5, 2, 2);
        bus_read_chk("iso_ulr", 2'b01, 8'd200);

        // error: inverted limits
        bus_write(2'b01, 8'd5);
        bus_write(2'b10, 8'd15);
        pulse_start();
        chk_outs("err_limits", 5, 0, 0, 1);
        repeat (3) tick();
        chk_outs("err_hold", 5, 0, 0, 1);

        // error: zero cycle count
        bus_write(2'b00, 8'd10);
        bus_write(2'b01, 8'd15);
        bus_write(2'b10, 8'd5);
        bus_write(2'b11, 8'd0);
        pulse_start();
        chk_outs("err_ccr0", 5, 0, 0, 1);

        // error: preload above upper limit
        bus_write(2'b11, 8'd2);
        bus_write(2'b00, 8'd20);
        pulse_start();
        chk_outs("err_plr", 5, 0, 0, 1);

        // valid start clears err and runs
        run_check("recover", 7, 15, 5, 2, 0);

        // randomized runs, including full-range boundaries
        for (int i = 0; i < 24; i++) begin
            span = $urandom_range(2, 12);
            if (i == 0) l = 0;
            else if (i == 1) l = 255 - span;
            else l = $urandom_range(0, 255 - span);
            u = l + span;
            p = $urandom_range(l, u);
            c = $urandom_range(1, 3);
            run_check("rand", p, u, l, c, (i >= 2) ? 1 : 0);
        end

        // reset mid-run clears everything at once
        bus_write(2'b00, 8'd50);
        bus_write(2'b01, 8'd60);
        bus_write(2'b10, 8'd40);
        bus_write(2'b11, 8'd3);
        pulse_start();
        repeat (5) tick();
        chk("pre_abort_count", int'(count), 55);
        #2;
        reset = 1'b0;
        #1;
        chk_outs("abort", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_read_chk("abort_reg", 2'(i), 8'h00);
        end
        tick();
        chk_outs("abort_idle", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
